i2c_scl_gen: RTL

- Parametrised SCL generator for the i2cMaster; next generation of the fixed divide-by-2 clock divider.
- Produces the internal SCL (iscl) with a runtime-programmable half-period.
- Produces single-cycle phase strobes for the bit-level FSM: SCL rise, SCL fall, mid-high sample, mid-low data-drive.
- Runs only while the master is busy; optionally honours slave clock stretching.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_phase_counter.sv | 44 ++++
 rtl/i2c_scl_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the i2cMaster SCL path: state encoding and divider defaults.
// The div_half CSR field width is exported here so the register block stays in step with the divider.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2,
    STRETCH = 2'd3
  } scl_state_e;

  localparam int SCL_DIV_W      = 16;
  localparam int SCL_MIN_HALF   = 2;
  localparam int CSR_DIV_HALF_W = SCL_DIV_W;

endpackage

// File: rtl/i2c_phase_counter.sv
// Loadable half-period counter for the SCL generator.
// Holds the running count and the latched half-period, and flags the terminal and mid-point counts.
module i2c_phase_counter
  import i2c_pkg::*;
#(
  parameter int DIV_W    = SCL_DIV_W,
  parameter int MIN_HALF = SCL_MIN_HALF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             terminal,
  output logic             next_zero,
  output logic             next_mid
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] half_q;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] half_next;

  always_comb begin
    cnt_next  = clear ? '0 : cnt + DIV_W'(1);
    half_next = load ? load_val : half_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      half_q <= DIV_W'(MIN_HALF);
    end else begin
      cnt    <= cnt_next;
      half_q <= half_next;
    end
  end

  // Compares on the next values let the top register its strobes in the same cycle the count lands.
  assign terminal  = (cnt == half_q - DIV_W'(1));
  assign next_zero = (cnt_next == '0);
  assign next_mid  = (cnt_next == (half_next >> 1));

endmodule

// File: rtl/i2c_scl_gen.sv
// SCL generator for the i2cMaster: programmable half-period, registered SCL and phase strobes.
// Define I2C_SCL_STRETCH_EN to wait on slave clock stretching at the end of every LOW phase.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int DIV_W    = SCL_DIV_W,
  parameter int MIN_HALF = SCL_MIN_HALF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             busy,
  input  logic [DIV_W-1:0] div_half,
  input  logic             scl_in,
  output logic             iscl,
  output logic             scl_rise,
  output logic             scl_fall,
  output logic             sample_tick,
  output logic             drive_tick,
  output logic             stretching
);

  localparam logic [DIV_W-1:0] MIN_HALF_V = DIV_W'(MIN_HALF);

  scl_state_e       state;
  scl_state_e       state_next;
  logic [DIV_W-1:0] eff_half;
  logic             clear;
  logic             load;
  logic             terminal;
  logic             next_zero;
  logic             next_mid;

  assign eff_half = (div_half < MIN_HALF_V) ? MIN_HALF_V : div_half;

  i2c_phase_counter #(
    .DIV_W    (DIV_W),
    .MIN_HALF (MIN_HALF)
  ) u_phase_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .load      (load),
    .load_val  (eff_half),
    .terminal  (terminal),
    .next_zero (next_zero),
    .next_mid  (next_mid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The half-period is latched only when a HIGH or LOW phase begins.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        clear = 1'b1;
        if (busy) begin
          state_next = HIGH;
          load       = 1'b1;
        end
      end
      HIGH: begin
        if (!busy) begin
          state_next = IDLE;
          clear      = 1'b1;
        end else if (terminal) begin
          state_next = LOW;
          clear      = 1'b1;
          load       = 1'b1;
        end
      end
      LOW: begin
        if (!busy) begin
          state_next = IDLE;
          clear      = 1'b1;
        end else if (terminal) begin
          clear = 1'b1;
`ifdef I2C_SCL_STRETCH_EN
          state_next = STRETCH;
`else
          state_next = HIGH;
          load       = 1'b1;
`endif
        end
      end
`ifdef I2C_SCL_STRETCH_EN
      STRETCH: begin
        clear = 1'b1;
        if (!busy) begin
          state_next = IDLE;
        end else if (scl_in) begin
          state_next = HIGH;
          load       = 1'b1;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        clear      = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      iscl        <= 1'b1;
      scl_rise    <= 1'b0;
      scl_fall    <= 1'b0;
      sample_tick <= 1'b0;
      drive_tick  <= 1'b0;
    end else begin
      iscl        <= (state_next != LOW);
      scl_rise    <= (state_next == HIGH) && next_zero;
      scl_fall    <= (state_next == LOW) && next_zero;
      sample_tick <= (state_next == HIGH) && next_mid;
      drive_tick  <= (state_next == LOW) && next_mid;
    end
  end

`ifdef I2C_SCL_STRETCH_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stretching <= 1'b0;
    end else begin
      stretching <= (state_next == STRETCH);
    end
  end
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stretching    = 1'b0;
`endif

endmodule
